// File: rtl/hsid_pkg.sv
// Shared widths and state encoding for the HSI library matcher datapaths.
// The MSE block's optional mean division is enabled by HSID_MSE_MEAN_EN.
package hsid_pkg;

  localparam int HSID_WORD_WIDTH     = 32;
  localparam int HSID_DATA_WIDTH     = 16;
  localparam int HSID_DATA_WIDTH_MUL = 32;
  localparam int HSID_DATA_WIDTH_ACC = 48;
  localparam int HSID_LENGTH_BITS    = 10;

  typedef enum logic [2:0] {
    MSE_IDLE   = 3'd0,
    MSE_RUN    = 3'd1,
    MSE_DRAIN  = 3'd2,
    MSE_DIVIDE = 3'd3,
    MSE_DONE   = 3'd4
  } hsid_mse_state_t;

endpackage

// File: rtl/hsid_sq_df.sv
// One lane of the MSE datapath: S1 registers the signed difference, S2 its square.
// A masked lane contributes a zero difference; the valid bit rides alongside.
module hsid_sq_df
  import hsid_pkg::*;
#(
  parameter int DATA_WIDTH     = HSID_DATA_WIDTH,
  parameter int DATA_WIDTH_MUL = HSID_DATA_WIDTH_MUL
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      in_valid,
  input  logic                      mask,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic                      out_valid,
  output logic [DATA_WIDTH_MUL-1:0] sq
);

  logic signed [DATA_WIDTH:0] d;
  logic                       d_valid;
  logic [DATA_WIDTH-1:0]      mag;

  // Squaring the magnitude keeps the multiplier unsigned and exactly 2*DATA_WIDTH wide.
  always_comb mag = d[DATA_WIDTH] ? DATA_WIDTH'(-d) : d[DATA_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d         <= '0;
      d_valid   <= 1'b0;
      sq        <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      d_valid   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      d_valid   <= in_valid;
      out_valid <= d_valid;
      if (in_valid) d <= mask ? '0 : ($signed({1'b0, a}) - $signed({1'b0, b}));
      if (d_valid) sq <= DATA_WIDTH_MUL'(mag) * DATA_WIDTH_MUL'(mag);
    end
  end

endmodule

// File: rtl/hsid_mse.sv
// Streaming sum-of-squared-differences engine fed two band samples per word.
// With HSID_MSE_MEAN_EN defined, a 48-cycle restoring divider returns the mean instead.
module hsid_mse
  import hsid_pkg::*;
#(
  parameter int WORD_WIDTH     = HSID_WORD_WIDTH,
  parameter int DATA_WIDTH     = HSID_DATA_WIDTH,
  parameter int DATA_WIDTH_MUL = HSID_DATA_WIDTH_MUL,
  parameter int DATA_WIDTH_ACC = HSID_DATA_WIDTH_ACC,
  parameter int LENGTH_BITS    = HSID_LENGTH_BITS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      start,
  input  logic [LENGTH_BITS-1:0]    vctr_len,
  input  logic                      word_valid,
  output logic                      word_ready,
  input  logic [WORD_WIDTH-1:0]     vctr_a,
  input  logic [WORD_WIDTH-1:0]     vctr_b,
  output logic                      idle,
  output logic                      mse_valid,
  output logic [DATA_WIDTH_ACC-1:0] mse_value,
  output hsid_mse_state_t           debug_state
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_DRAIN  = 3'd2;
  localparam logic [2:0] ST_DIVIDE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Handshake: a word moves on a cycle where word_valid && word_ready; word_ready
  // depends only on state and remaining count, never on word_valid.
  logic [2:0]                state, state_nxt;
  logic [LENGTH_BITS-1:0]    words_left;
  logic                      odd_len;
  logic                      drain_cnt;
  logic                      start_ok, transfer, mask_lane1;
  logic                      s2_valid0, s2_valid1;
  logic [DATA_WIDTH_MUL-1:0] sq0, sq1;
  logic [DATA_WIDTH_ACC-1:0] acc;

`ifdef HSID_MSE_MEAN_EN
  localparam int CNT_W = $clog2(DATA_WIDTH_ACC);
  logic [LENGTH_BITS-1:0]    len_q;
  logic [DATA_WIDTH_ACC-1:0] div_q, div_q_nxt;
  logic [LENGTH_BITS-1:0]    div_r, div_r_nxt;
  logic [CNT_W-1:0]          div_cnt;
  assign odd_len = len_q[0];
`else
  logic odd_q;
  assign odd_len = odd_q;
`endif

  assign start_ok    = start && (state == ST_IDLE);
  assign word_ready  = (state == ST_RUN) && (words_left != '0);
  assign transfer    = word_valid && word_ready;
  assign mask_lane1  = odd_len && (words_left == LENGTH_BITS'(1));
  assign idle        = (state == ST_IDLE);
  assign mse_valid   = (state == ST_DONE);
  assign debug_state = hsid_mse_state_t'(state);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = (vctr_len != '0) ? ST_RUN : ST_DONE;
      ST_RUN:   if (words_left == '0) state_nxt = ST_DRAIN;
`ifdef HSID_MSE_MEAN_EN
      ST_DRAIN:  if (drain_cnt) state_nxt = ST_DIVIDE;
      ST_DIVIDE: if (div_cnt == '0) state_nxt = ST_DONE;
`else
      ST_DRAIN:  if (drain_cnt) state_nxt = ST_DONE;
`endif
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (clear) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  hsid_sq_df #(.DATA_WIDTH(DATA_WIDTH), .DATA_WIDTH_MUL(DATA_WIDTH_MUL)) u_lane0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(transfer), .mask(1'b0),
    .a(vctr_a[DATA_WIDTH-1:0]), .b(vctr_b[DATA_WIDTH-1:0]),
    .out_valid(s2_valid0), .sq(sq0)
  );

  hsid_sq_df #(.DATA_WIDTH(DATA_WIDTH), .DATA_WIDTH_MUL(DATA_WIDTH_MUL)) u_lane1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(transfer), .mask(mask_lane1),
    .a(vctr_a[2*DATA_WIDTH-1:DATA_WIDTH]), .b(vctr_b[2*DATA_WIDTH-1:DATA_WIDTH]),
    .out_valid(s2_valid1), .sq(sq1)
  );

`ifdef HSID_MSE_MEAN_EN
  // One quotient bit per cycle: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    logic [LENGTH_BITS:0] shifted;
    shifted   = {div_r, div_q[DATA_WIDTH_ACC-1]};
    div_q_nxt = {div_q[DATA_WIDTH_ACC-2:0], 1'b0};
    div_r_nxt = shifted[LENGTH_BITS-1:0];
    if (shifted >= {1'b0, len_q}) begin
      div_r_nxt    = LENGTH_BITS'(shifted - {1'b0, len_q});
      div_q_nxt[0] = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_left <= '0;
      drain_cnt  <= 1'b0;
      acc        <= '0;
      mse_value  <= '0;
`ifdef HSID_MSE_MEAN_EN
      len_q      <= '0;
      div_q      <= '0;
      div_r      <= '0;
      div_cnt    <= '0;
`else
      odd_q      <= 1'b0;
`endif
    end else if (clear) begin
      words_left <= '0;
      drain_cnt  <= 1'b0;
      acc        <= '0;
      mse_value  <= '0;
    end else begin
      drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
      if (s2_valid0 && s2_valid1)
        acc <= acc + DATA_WIDTH_ACC'(sq0) + DATA_WIDTH_ACC'(sq1);
      if (start_ok) begin
        words_left <= (vctr_len >> 1) + {{(LENGTH_BITS-1){1'b0}}, vctr_len[0]};
        acc        <= '0;
        mse_value  <= '0;
`ifdef HSID_MSE_MEAN_EN
        len_q      <= vctr_len;
`else
        odd_q      <= vctr_len[0];
`endif
      end else if (transfer) begin
        words_left <= words_left - LENGTH_BITS'(1);
      end
`ifdef HSID_MSE_MEAN_EN
      if (state == ST_DRAIN && drain_cnt) begin
        div_q   <= acc;
        div_r   <= '0;
        div_cnt <= CNT_W'(DATA_WIDTH_ACC - 1);
      end
      if (state == ST_DIVIDE) begin
        div_q   <= div_q_nxt;
        div_r   <= div_r_nxt;
        div_cnt <= div_cnt - CNT_W'(1);
        if (div_cnt == '0) mse_value <= div_q_nxt;
      end
`else
      if (state == ST_DRAIN && drain_cnt) mse_value <= acc;
`endif
    end
  end

endmodule

// File: tb/tb_hsid_mse.sv
// Bench for hsid_mse: directed vector table, clear/busy-start sequences and
// randomized vectors checked against a band-by-band arithmetic model.
module tb_hsid_mse;
  import hsid_pkg::*;

`ifdef HSID_MSE_MEAN_EN
  localparam int DIV_LAT = 48;
`else
  localparam int DIV_LAT = 0;
`endif
  localparam int BUDGET = 2000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clear = 1'b0;
  logic            start = 1'b0;
  logic [9:0]      vctr_len = '0;
  logic            word_valid = 1'b0;
  logic            word_ready;
  logic [31:0]     vctr_a = '0;
  logic [31:0]     vctr_b = '0;
  logic            idle;
  logic            mse_valid;
  logic [47:0]     mse_value;
  hsid_mse_state_t dbg_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] wa[512];
  logic [31:0] wb[512];

  typedef struct {
    string       name;
    int          len;
    int          gap_mode;   // 0 back-to-back, 1 alternate, 2 random
    bit          busy_start;
    logic [31:0] a[4];
    logic [31:0] b[4];
    logic [47:0] exp_sum;
    logic [47:0] exp_mean;
    int          exp_lat;    // cycles from start edge to pulse, raw-sum build
  } vec_t;

  vec_t tbl[7];

  hsid_mse dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .vctr_len(vctr_len),
    .word_valid(word_valid), .word_ready(word_ready), .vctr_a(vctr_a), .vctr_b(vctr_b),
    .idle(idle), .mse_valid(mse_valid), .mse_value(mse_value), .debug_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: walk every band, square its difference, sum; optionally take the mean.
  function automatic logic [47:0] model(input int len);
    longint s;
    s = 0;
    for (int i = 0; i < len; i++) begin
      int av, bv;
      logic [31:0] wda, wdb;
      wda = wa[i / 2];
      wdb = wb[i / 2];
      av = (i % 2 == 1) ? int'(wda[31:16]) : int'(wda[15:0]);
      bv = (i % 2 == 1) ? int'(wdb[31:16]) : int'(wdb[15:0]);
      s += longint'(av - bv) * longint'(av - bv);
    end
`ifdef HSID_MSE_MEAN_EN
    if (len != 0) s = s / len;
`endif
    return s[47:0];
  endfunction

  // Runs one vector from the start edge to the mse_valid pulse; exp_lat < 0 means
  // the pulse is expected 4 (+divide) cycles after the last accepted word.
  task automatic run_vec(input string name, input int len, input int gap_mode,
                         input bit busy_start, input logic [47:0] exp_val, input int exp_lat);
    int n, wi, nwords, last_n, pulse_n, want_lat;
    bit stray;
    logic [47:0] got;
    nwords = (len + 1) / 2;
    wi = 0; last_n = 0; pulse_n = -1; stray = 1'b0; got = '0;
    @(negedge clk);
    start = 1'b1; vctr_len = 10'(len); word_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy"}, {63'd0, idle}, 64'd0);
    for (n = 1; n <= BUDGET; n++) begin
      if (busy_start) begin
        start = (n == 1);
        vctr_len = 10'd9;
      end
      case (gap_mode)
        0:       word_valid = 1'b1;
        1:       word_valid = (n % 2 == 1);
        default: word_valid = ($urandom_range(0, 3) != 0);
      endcase
      vctr_a = (wi < nwords) ? wa[wi] : $urandom;
      vctr_b = (wi < nwords) ? wb[wi] : $urandom;
      if (mse_valid) begin
        pulse_n = n;
        got = mse_value;
        word_valid = 1'b0;
        start = 1'b0;
        break;
      end
      if (word_ready) begin
        if (wi >= nwords) stray = 1'b1;
        else if (word_valid) begin
          wi++;
          last_n = n;
        end
      end
      @(negedge clk);
    end
    if (pulse_n < 0) $display("FAIL %s_timeout got no pulse expected pulse within %0d cycles", name, BUDGET);
    want_lat = (exp_lat >= 0) ? exp_lat : last_n + 4 + DIV_LAT;
    check({name, "_lat"}, 64'(pulse_n), 64'(want_lat));
    check({name, "_value"}, {16'd0, got}, {16'd0, exp_val});
    check({name, "_words"}, 64'(wi), 64'(nwords));
    check({name, "_no_extra_ready"}, {63'd0, stray}, 64'd0);
    @(negedge clk);
    check({name, "_idle_after"}, {63'd0, idle}, 64'd1);
    check({name, "_held"}, {16'd0, mse_value}, {16'd0, exp_val});
  endtask

  task automatic load_row(input int r);
    for (int i = 0; i < 4; i++) begin
      wa[i] = tbl[r].a[i];
      wb[i] = tbl[r].b[i];
    end
  endtask

  initial begin
    int lat;
    logic [47:0] ev;
    bit pulse_seen;

    tbl[0] = '{"len4", 4, 0, 1'b0, '{32'h0001_0003, 32'h0010_0000, 0, 0}, '{0, 0, 0, 0},
               48'd266, 48'd66, 6};
    tbl[1] = '{"len3_odd", 3, 0, 1'b0, '{32'h0005_0005, 32'h0007_0005, 0, 0}, '{0, 0, 0, 0},
               48'd75, 48'd25, 6};
    tbl[2] = '{"len2_ext", 2, 0, 1'b0, '{32'h0000_3FFF, 0, 0, 0}, '{32'h3FFF_0000, 0, 0, 0},
               48'd536805378, 48'd268402689, 5};
    tbl[3] = '{"len8_b2b", 8, 0, 1'b0,
               '{32'h0002_0001, 32'h0004_0003, 32'h0006_0005, 32'h0008_0007}, '{0, 0, 0, 0},
               48'd204, 48'd25, 8};
    tbl[4] = '{"len8_gap", 8, 1, 1'b0,
               '{32'h0002_0001, 32'h0004_0003, 32'h0006_0005, 32'h0008_0007}, '{0, 0, 0, 0},
               48'd204, 48'd25, 11};
    tbl[5] = '{"len0", 0, 0, 1'b0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 48'd0, 48'd0, 1};
    tbl[6] = '{"busy_start", 4, 0, 1'b1, '{32'h0001_0003, 32'h0010_0000, 0, 0}, '{0, 0, 0, 0},
               48'd266, 48'd66, 6};

    // Clock/reset
    repeat (3) @(negedge clk);
    check("rst_word_ready", {63'd0, word_ready}, 64'd0);
    check("rst_mse_valid", {63'd0, mse_valid}, 64'd0);
    check("rst_mse_value", {16'd0, mse_value}, 64'd0);
    check("rst_idle", {63'd0, idle}, 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {63'd0, idle}, 64'd1);

    // Directed table
    for (int r = 0; r < 7; r++) begin
      load_row(r);
`ifdef HSID_MSE_MEAN_EN
      ev = tbl[r].exp_mean;
`else
      ev = tbl[r].exp_sum;
`endif
      lat = tbl[r].exp_lat + ((tbl[r].len == 0) ? 0 : DIV_LAT);
      run_vec(tbl[r].name, tbl[r].len, tbl[r].gap_mode, tbl[r].busy_start, ev, lat);
    end

    // Clear after two of four words
    load_row(3);
    @(negedge clk);
    start = 1'b1; vctr_len = 10'd8;
    @(negedge clk);
    start = 1'b0; word_valid = 1'b1;
    for (int n = 0; n < 2; n++) begin
      vctr_a = wa[n]; vctr_b = wb[n];
      check("clr_ready_before", {63'd0, word_ready}, 64'd1);
      @(negedge clk);
    end
    word_valid = 1'b0; clear = 1'b1; start = 1'b1;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    check("clr_idle", {63'd0, idle}, 64'd1);
    check("clr_value", {16'd0, mse_value}, 64'd0);
    check("clr_ready", {63'd0, word_ready}, 64'd0);
    pulse_seen = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (mse_valid) pulse_seen = 1'b1;
      if (!idle) pulse_seen = 1'b1;
      @(negedge clk);
    end
    check("clr_quiet", {63'd0, pulse_seen}, 64'd0);
    run_vec("after_clr", 8, 0, 1'b0, model(8), 8 + DIV_LAT);

    // Randomized vectors against the model
    for (int k = 0; k < 16; k++) begin
      int len;
      len = (k == 0) ? 1023 : $urandom_range(0, 60);
      for (int i = 0; i < 512; i++) begin
        wa[i] = (k == 0) ? 32'hFFFF_FFFF : $urandom;
        wb[i] = (k == 0) ? 32'h0000_0000 : $urandom;
      end
      run_vec($sformatf("rand%0d_len%0d", k, len), len, 2, 1'b0, model(len),
              (len == 0) ? 1 : -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hsid_mse.md
# hsid_mse

Streaming mean-squared-error datapath for the HSI library matcher. It sits directly downstream of the main matching FSM. During its COMPUTE_MSE/WAIT_MSE states, the FSM streams 32-bit words to this block, each holding two 16-bit band samples of the measured pixel and of one library pixel. The block subtracts, squares and accumulates the samples, then returns one 48-bit error value per vector for the FSM's COMPARE_MSE step.

## Interface
Parameters:
- WORD_WIDTH, HSID_WORD_WIDTH (32): input word width.
- DATA_WIDTH, HSID_DATA_WIDTH (16): sample width. Unsigned; bits [15:14] are zero in valid data but still enter the computation.
- DATA_WIDTH_MUL, HSID_DATA_WIDTH_MUL (32): width of one squared difference.
- DATA_WIDTH_ACC, HSID_DATA_WIDTH_ACC (48): accumulator and result width.
- LENGTH_BITS, HSID_LENGTH_BITS (10): width of the band count.

Ports (one clock; reset is asynchronous and active-low):
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- clear, in, 1: synchronous abort; highest priority after reset.
- start, in, 1: latch vctr_len and begin a vector; ignored unless idle.
- vctr_len, in, LENGTH_BITS: number of bands (0..1023).
- word_valid, in, 1: a word pair is presented.
- word_ready, out, 1: the block accepts a word this cycle.
- vctr_a, in, WORD_WIDTH: measured pixel word; lane0 = [15:0], lane1 = [31:16].
- vctr_b, in, WORD_WIDTH: library pixel word, same packing.
- idle, out, 1: FSM is in IDLE.
- mse_valid, out, 1: one-cycle pulse when mse_value is updated.
- mse_value, out, DATA_WIDTH_ACC: result, held until the next start or clear.

## Operation
- FSM states:
  - IDLE: on start, go to RUN if vctr_len > 0, otherwise go to DONE.
  - RUN: accepts ceil(len/2) words. Moves to DRAIN in the cycle after the last word is accepted.
  - DRAIN: waits 2 cycles for the pipeline to empty.
  - DIVIDE: present only with the macro.
  - DONE: lasts 1 cycle, pulses mse_valid, then returns to IDLE.
- Word transfer happens when word_valid && word_ready. word_ready = (state == RUN) && words remaining > 0.
- Pipeline, per lane:
  - S1: d = a − b, signed 17-bit.
  - S2: sq = d*d, unsigned 32-bit.
  - S3: acc += sq_lane0 + sq_lane1 (48-bit, zero-extended).
  - A bubble (no transfer) advances a valid bit with no effect on acc.
- Odd vctr_len: on the last word, lane1 is masked (its difference is forced to 0).
- The accumulator is cleared on start. The maximum sum is 1023·65535² < 2^42, so no overflow is possible.
- Without the macro, mse_value = acc, i.e. the sum of squared differences.
- vctr_len = 0: mse_value = 0, with no words accepted.
- start while not idle is ignored. word_valid outside RUN is ignored.
- clear, in any state:
  - next state is IDLE;
  - pipeline valid bits and acc are zeroed;
  - mse_value = 0;
  - no mse_valid pulse;
  - a start in the same cycle is ignored.
- Reset values: word_ready = 0, mse_valid = 0, mse_value = 0, idle = 1, state = IDLE.

## Timing
- Start is sampled at cycle t. RUN begins at t+1, and word_ready may be high from t+1.
- With no bubbles, the last word for len = 32 (16 words) is accepted at t+16.
- Without the macro, mse_valid pulses 4 cycles after the last word is accepted: 2 DRAIN cycles, acc settles, then the DONE pulse. For len = 32 the pulse is at t+20.
- vctr_len = 0: mse_valid pulses at t+1.
- idle drops the cycle after start and returns high the cycle after the mse_valid pulse. A new start is accepted once idle is high.

## Configuration
- HSID_MSE_MEAN_EN:
  - Defined: after DRAIN, the FSM enters DIVIDE. A restoring divider computes mse_value = acc / vctr_len (quotient, truncated), one bit per cycle, taking exactly 48 cycles. This adds 48 cycles to the mse_valid latency. vctr_len = 0 still yields 0 with no divide.
  - Undefined: the DIVIDE state and divider logic are absent, and mse_value is the raw sum.

## Structure
- Add hsid_mse_state_t {MSE_IDLE, MSE_RUN, MSE_DRAIN, MSE_DIVIDE, MSE_DONE} to hsid_pkg. Reuse the existing width constants from the package.
- Sub-module hsid_sq_df: a one-lane, two-stage subtract/square pipeline with a lane mask and valid pass-through. It is instantiated twice.
- The divider stays inline in hsid_mse under the macro.

## Test plan
- len = 4, words A = {0x0003,0x0001},{0x0000,0x0010}, B = all zero → mse_value = 1+9+256+0 = 266 (mean build: 66); mse_valid at t+6 (+48).
- len = 3: A lanes = 5,5,5 and 7; B = 0; the 7 sits in lane1 of the last word, which is masked → sum = 75 (mean: 25); exactly 2 words accepted.
- len = 2 with extremes: A = 0x3FFF/0x0000, B = 0x0000/0x3FFF → sum = 2·16383² = 536805378; this checks that the difference sign is irrelevant.
- word_valid toggling 1-0-1-0, len = 8 → same result as back-to-back input; word_ready never high after the 4th word.
- clear asserted mid-RUN after 2 of 8 words → idle the next cycle, mse_value = 0, no pulse; a fresh start then gives the correct result.
- len = 0 → mse_valid at t+1 with value 0. A start while busy → ignored, and the result is unchanged.
